dual_diagonal_forward: RTL and testbench
========================================

Name: dual_diagonal_forward

Overview:
- Inverse of the dual-diagonal back-substitution accumulator: per frame, out[k] = in[k] XOR in[k-1], with in[-1] = 0.
- Sits on the LDPC decoder/check side. It recovers the pre-accumulation word stream from a parity-accumulated stream.
- Adds full valid/ready flow control, a runtime frame length, last-marker generation and frame-alignment checking.
- Chaining back-substitution then this block must reproduce the original stream bit-exactly.

Parameters:
- WIDTH, 8, data word width in bits.
- MAX_WORDS, 1024, maximum frame length in words (≥2). LEN_W = $clog2(MAX_WORDS).

Ports:
- clock  input  1  single clock; all logic is rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- cfg_num_words_m1  input  LEN_W  frame length minus 1; sampled only on the first accepted word of a frame.
- in_data  input  WIDTH  accumulated input word.
- in_valid  input  1  in_data valid.
- in_last  input  1  upstream end-of-frame marker; used only for checking/early termination.
- in_ready  output  1  block can accept a word this cycle.
- out_data  output  WIDTH  differenced word.
- out_valid  output  1  out_data valid.
- out_last  output  1  final word of frame, qualified by out_valid.
- out_ready  input  1  downstream accepts the output word.
- frame_error  output  1  one-cycle pulse on a frame-alignment mismatch.
- busy  output  1  high while a frame is in progress (state RUN).

Behaviour:
- Reset (async assert, synchronous deassert by the integrator):
  - Outputs: out_valid=0, out_last=0, out_data=0, frame_error=0, busy=0, in_ready=0.
  - Internal: prev=0, word_count=0, len_q=0, state=IDLE, skid empty.
  - in_ready rises on the first clock edge after reset_n deasserts.
- Acceptance occurs on a cycle with in_valid && in_ready.
- State machine IDLE:
  - On acceptance: len_q <= cfg_num_words_m1, compute word 0, word_count <= 1.
  - Go to RUN, unless len_q would be 0 (single-word frame) or in_last=1; in those cases emit out_last and stay in IDLE.
- State machine RUN:
  - Each acceptance computes in_data ^ prev, then prev <= in_data and word_count++.
  - Terminal word is word_count == len_q, or in_last=1 earlier (early termination).
  - On the terminal word: out_last=1, prev <= 0, word_count <= 0, go to IDLE.
- Data path: result = in_data ^ prev. prev is the raw input, not the output. Pure bitwise XOR with no width growth.
- Alignment check, raising frame_error one cycle after the offending acceptance:
  - (a) in_last=1 on a non-terminal count (early); the frame still terminates there.
  - (b) count reaches len_q with in_last=0; the frame still terminates on count.
  - frame_error never stalls the data path.
- Latency and buffering:
  - Output register plus 1-entry skid buffer; in_ready is a registered output.
  - Latency is 1 cycle from acceptance to out_valid when the output stage is empty or draining.
  - in_ready = !skid_full. Throughput is 1 word/cycle while out_ready=1.
  - When out_ready drops with the output register full, the next accepted word goes to the skid and in_ready falls the following cycle.
  - Skid drains into the output register before any new input. Order is preserved; no word is dropped or duplicated.
- out_data, out_last and out_valid stay stable while out_valid && !out_ready.
- Simultaneous events:
  - Acceptance of a terminal word and the first word of the next frame on consecutive cycles is legal with no bubble; the new frame samples cfg_num_words_m1 on its first word.
  - Output pop and input push in the same cycle with the skid empty: the register is reloaded directly and the skid stays empty.
- cfg_num_words_m1 changes mid-frame have no effect until the next frame.
- reset_n asserted mid-frame:
  - Immediate abort; all state returns to reset values.
  - Words held in output/skid are discarded; out_valid drops asynchronously.
- busy = (state == RUN).

Test Plan:
- Basic difference: cfg_num_words_m1=3, inputs 0x01,0x03,0x07,0x0F, out_ready=1 -> outputs 0x01,0x02,0x04,0x08, out_last on 4th, 1-cycle latency, frame_error=0.
- Inverse check: random 1024-word frames run through back-substitution then this block (cfg=1023) -> output equals original stimulus bit-exactly; out_last every 1024th word; prev cleared between frames.
- Backpressure: out_ready toggled 1,0,0,1 pseudo-randomly over 64 words -> no loss or duplication, output held stable while stalled, in_ready low while skid full, sequence matches model.
- Alignment errors:
  - in_last=1 on word 2 of cfg=7 frame -> out_last on word 2 and frame_error pulse; next frame starts with prev=0.
  - in_last=0 at count 7 -> out_last on word 7 and frame_error pulse.
- Back-to-back and config: frame A cfg=2, frame B cfg=0 (single word 0x5A), cfg changed mid-frame A -> A uses 3 words, B outputs 0x5A with out_last, no bubbles.
- Async reset mid-frame: assert reset_n=0 at word 5 with stalled output -> out_valid=0 immediately, busy=0. After release, a new frame 0xAA,0xFF -> 0xAA,0x55.

Source files
------------

// File: rtl/dual_diagonal_forward.sv
// Dual-diagonal forward differencer: out[k] = in[k] ^ in[k-1] per frame, with
// valid/ready flow control, runtime frame length and frame-alignment checking.
module dual_diagonal_forward #(
  parameter  int WIDTH     = 8,
  parameter  int MAX_WORDS = 1024,
  localparam int LEN_W     = $clog2(MAX_WORDS)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [LEN_W-1:0] cfg_num_words_m1,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             frame_error,
  output logic             busy
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] prev, prev_nxt, res;
  logic [LEN_W-1:0] cnt, cnt_nxt, len_q, len_nxt;
  logic             at_count, term, err_nxt, acc, pop;
  logic [WIDTH-1:0] skid_data;
  logic             skid_last, skid_full;

  assign acc  = in_valid && in_ready;
  assign pop  = out_valid && out_ready;
  assign busy = (state == RUN);

  // Frame sequencing; the first word of a frame compares against the live cfg
  // because len_q only captures it on that same edge.
  always_comb begin
    state_nxt = state;
    prev_nxt  = prev;
    cnt_nxt   = cnt;
    len_nxt   = len_q;
    err_nxt   = 1'b0;
    res       = in_data ^ prev;
    at_count  = (state == IDLE) ? (cfg_num_words_m1 == '0) : (cnt == len_q);
    term      = at_count || in_last;
    if (acc) begin
      err_nxt = at_count ^ in_last;
      if (state == IDLE) len_nxt = cfg_num_words_m1;
      if (term) begin
        state_nxt = IDLE;
        prev_nxt  = '0;
        cnt_nxt   = '0;
      end else begin
        state_nxt = RUN;
        prev_nxt  = in_data;
        cnt_nxt   = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      prev        <= '0;
      cnt         <= '0;
      len_q       <= '0;
      frame_error <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      out_valid   <= 1'b0;
      skid_data   <= '0;
      skid_last   <= 1'b0;
      skid_full   <= 1'b0;
      in_ready    <= 1'b0;
    end else begin
      state       <= state_nxt;
      prev        <= prev_nxt;
      cnt         <= cnt_nxt;
      len_q       <= len_nxt;
      frame_error <= err_nxt;
      // Skid always refills the output register before any new word.
      if (skid_full) begin
        if (pop) begin
          out_data  <= skid_data;
          out_last  <= skid_last;
          skid_full <= 1'b0;
        end
      end else if (!out_valid || pop) begin
        out_valid <= acc;
        if (acc) begin
          out_data <= res;
          out_last <= term;
        end
      end else if (acc) begin
        skid_data <= res;
        skid_last <= term;
        skid_full <= 1'b1;
      end
      in_ready <= skid_full ? pop : !(out_valid && !pop && acc);
    end
  end

endmodule

// File: tb/tb_dual_diagonal_forward.sv
// Scoreboard bench for dual_diagonal_forward: driver pushes expected words,
// a negedge monitor pops and compares, plus hold-stability and error checks.
module tb_dual_diagonal_forward;
  localparam int WIDTH = 8, MAX_WORDS = 1024, LEN_W = 10;

  logic             clock = 1'b0, reset_n = 1'b0;
  logic [LEN_W-1:0] cfg_num_words_m1 = '0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0, in_last = 1'b0, in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid, out_last, frame_error, busy;
  logic             out_ready = 1'b0;

  dual_diagonal_forward #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
    .clock(clock), .reset_n(reset_n), .cfg_num_words_m1(cfg_num_words_m1),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .frame_error(frame_error), .busy(busy));

  always #5 clock = ~clock;

  typedef struct packed { logic [WIDTH-1:0] d; logic l; } exp_t;
  exp_t             exp_q[$];
  bit               err_q[$];
  logic [WIDTH-1:0] stim[$], expd[$];
  int n_checks = 0, n_fail = 0;
  int cyc = 0, acc_cyc = 0, first_cyc = 0, out_cyc = 0;
  bit mon_en = 1'b0;
  int rdy_mode = 0;

  always @(posedge clock) cyc++;

  always @(posedge clock) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  // Monitor
  bit               hold_v = 1'b0, err_pend = 1'b0;
  logic [WIDTH-1:0] hold_d;
  logic             hold_l;
  always @(negedge clock) begin
    if (!mon_en) begin
      hold_v   = 1'b0;
      err_pend = 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hold_d);
        check("hold_last", out_last, hold_l);
      end
      if (err_pend) begin
        if (err_q.size() == 0) check("err_queue_empty", 0, 1);
        else check("frame_error", frame_error, err_q.pop_front());
      end else check("frame_error_idle", frame_error, 0);
      err_pend = in_valid && in_ready;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_output", out_data, 0 - 1);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_data", out_data, e.d);
          check("out_last", out_last, e.l);
        end
        out_cyc = cyc;
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      hold_l = out_last;
    end
  end

  // Driver: sends stim[0..term]; expected word k is expd[k].
  task automatic send_frame(input int cfg, input int last_at, input bit gaps, input bit keep_valid);
    int term;
    term = (last_at >= 0 && last_at < cfg) ? last_at : cfg;
    for (int k = 0; k <= term; k++) begin
      int   t;
      exp_t e;
      if (gaps) while ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clock); #1;
      end
      in_valid = 1'b1;
      in_data  = stim[k];
      in_last  = (k == last_at);
      cfg_num_words_m1 = (k == 0) ? LEN_W'(cfg) : LEN_W'($urandom);
      t = 0;
      @(negedge clock);
      while (!in_ready) begin
        t++;
        if (t > 500) begin
          check("in_ready_timeout", 0, 1);
          summary();
        end
        @(negedge clock);
      end
      e.d = expd[k];
      e.l = (k == term);
      exp_q.push_back(e);
      err_q.push_back((k == term) && ((k == cfg) != (k == last_at)));
      if (k == 0) first_cyc = cyc;
      acc_cyc = cyc;
      @(posedge clock); #1;
    end
    if (!keep_valid) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic rand_diff(input int n);
    stim.delete(); expd.delete();
    for (int k = 0; k < n; k++) stim.push_back(WIDTH'($urandom));
    for (int k = 0; k < n; k++) expd.push_back(stim[k] ^ ((k == 0) ? '0 : stim[k-1]));
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin @(posedge clock); t++; end
    repeat (3) @(posedge clock);
    #1;
    check("drain_outputs", exp_q.size(), 0);
    check("drain_errors", err_q.size(), 0);
  endtask

  initial begin
    int a_end;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_frame_error", frame_error, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    @(posedge clock); #1;
    check("in_ready_after_reset", in_ready, 1);

    // Basic difference
    stim = '{8'h01, 8'h03, 8'h07, 8'h0F};
    expd = '{8'h01, 8'h02, 8'h04, 8'h08};
    send_frame(3, 3, 0, 0);
    repeat (3) @(posedge clock);
    check("latency", out_cyc - acc_cyc, 1);
    drain();

    // Inverse of back-substitution over full-length frames
    for (int f = 0; f < 3; f++) begin
      logic [WIDTH-1:0] a;
      a = '0;
      stim.delete(); expd.delete();
      for (int k = 0; k < MAX_WORDS; k++) begin
        expd.push_back(WIDTH'($urandom));
        a = a ^ expd[k];
        stim.push_back(a);
      end
      rdy_mode = (f == 2) ? 1 : 0;
      send_frame(MAX_WORDS - 1, MAX_WORDS - 1, f[0], 0);
    end
    drain();
    rdy_mode = 0;

    // Backpressure
    rdy_mode = 1;
    rand_diff(64); send_frame(63, 63, 0, 0);
    rand_diff(64); send_frame(63, 63, 1, 0);
    drain();
    rdy_mode = 0;

    // Alignment: early in_last, then a clean frame to confirm prev was cleared
    rand_diff(8); send_frame(7, 2, 0, 1);
    rand_diff(4); send_frame(3, 3, 0, 0);
    drain();
    // Alignment: count reached without in_last
    rand_diff(8); send_frame(7, -1, 0, 0);
    drain();

    // Back-to-back frames, cfg scrambled mid-frame by the driver
    rand_diff(3); send_frame(2, 2, 0, 1);
    a_end = acc_cyc;
    stim = '{8'h5A}; expd = '{8'h5A};
    send_frame(0, 0, 0, 0);
    check("no_bubble", first_cyc - a_end, 1);
    drain();

    // Async reset mid-frame with stalled output
    mon_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = WIDTH'($urandom); in_last = 1'b0; cfg_num_words_m1 = 7;
      @(posedge clock); #1;
    end
    rdy_mode = 2;
    repeat (3) begin in_data = WIDTH'($urandom); @(posedge clock); #1; end
    in_valid = 1'b0;
    check("busy_mid_frame", busy, 1);
    check("stalled_valid", out_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    exp_q.delete(); err_q.delete();
    @(negedge clock);
    reset_n  = 1'b1;
    rdy_mode = 0;
    @(posedge clock); #1;
    mon_en = 1'b1;
    stim = '{8'hAA, 8'hFF}; expd = '{8'hAA, 8'h55};
    send_frame(1, 1, 0, 0);
    drain();

    summary();
  end

endmodule
